// File: rtl/mmul_parallel_kernel_sequencer.sv
// Engine-side sequencer for the mmul_parallel kernel wrapper.
// Issues one-cycle start pulses to the wrapper, counts its per-output done
// pulses against a programmed job length, and reports busy / done / sticky
// protocol errors back to hwpe-ctrl.
//
// Handshake: a start is issued only in ISSUE (one cycle per start). A new
// start leaves WAIT only when enable_i and k_ready_i are both high, the job
// still needs starts, and fewer than MAX_OUTSTANDING starts are unmatched by
// dones (a done arriving in the same cycle frees its slot immediately).
module mmul_parallel_kernel_sequencer #(
    parameter int unsigned CNT_LEN         = 1024,
    parameter int unsigned CNT_W           = $clog2(CNT_LEN) + 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             trigger_i,
    input  logic [CNT_W-1:0] n_out_i,
    output logic             k_start_o,
    output logic             k_clear_o,
    input  logic             k_done_i,
    input  logic             k_ready_i,
    input  logic             k_idle_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_out_o,
    output logic [CNT_W-1:0] cnt_start_o,
    output logic             err_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] n_out_q, n_out_d;
    logic [CNT_W-1:0] cnt_start_q, cnt_start_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             err_q, err_d;

    logic             in_job;
    logic [CNT_W-1:0] outstanding;
    logic             done_ok;
    logic [CNT_W-1:0] cnt_out_inc;
    logic [CNT_W-1:0] outstanding_now;

    // Done accounting shared by ISSUE and WAIT; the pre-increment start count
    // is used so a done never matches the start issued in the same cycle.
    always_comb begin
        in_job          = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
        outstanding     = cnt_start_q - cnt_out_q;
        done_ok         = k_done_i && in_job && (outstanding != '0);
        cnt_out_inc     = cnt_out_q + CNT_W'(done_ok);
        outstanding_now = outstanding - CNT_W'(done_ok);
    end

    // Next-state, counter and error logic; clear_i overrides everything.
    always_comb begin
        state_d     = state_q;
        n_out_d     = n_out_q;
        cnt_start_d = cnt_start_q;
        cnt_out_d   = cnt_out_q;
        err_d       = err_q;
        if (clear_i) begin
            state_d     = ST_IDLE;
            cnt_start_d = '0;
            cnt_out_d   = '0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (k_done_i) err_d = 1'b1;
                    if (trigger_i && enable_i) begin
                        n_out_d     = n_out_i;
                        cnt_start_d = '0;
                        cnt_out_d   = '0;
                        state_d     = (n_out_i == '0) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt_start_q < n_out_q) cnt_start_d = cnt_start_q + CNT_W'(1);
                    cnt_out_d = cnt_out_inc;
                    if (k_done_i && !done_ok) err_d = 1'b1;
                    state_d = (cnt_out_inc == n_out_q) ? ST_FINISH : ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_out_d = cnt_out_inc;
                    if (k_done_i && !done_ok) err_d = 1'b1;
                    // Kernel reporting idle while starts are unmatched is a fault.
                    if (k_idle_i && (outstanding != '0)) err_d = 1'b1;
                    if (cnt_out_inc == n_out_q) begin
                        state_d = ST_FINISH;
                    end else if (enable_i && k_ready_i && (cnt_start_q < n_out_q)
                                 && (outstanding_now < MAX_OUT)) begin
                        state_d = ST_ISSUE;
                    end
                end
                default: begin
                    if (k_done_i) err_d = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            n_out_q     <= '0;
            cnt_start_q <= '0;
            cnt_out_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_out_q     <= n_out_d;
            cnt_start_q <= cnt_start_d;
            cnt_out_q   <= cnt_out_d;
            err_q       <= err_d;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        k_start_o   = (state_q == ST_ISSUE) && !clear_i;
        k_clear_o   = clear_i;
        busy_o      = in_job;
        done_o      = (state_q == ST_FINISH);
        cnt_out_o   = cnt_out_q;
        cnt_start_o = cnt_start_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_mmul_parallel_kernel_sequencer.sv
// Directed bench for mmul_parallel_kernel_sequencer (default parameters:
// CNT_W = 11, MAX_OUTSTANDING = 2).
module tb_mmul_parallel_kernel_sequencer;

    localparam int W = 11;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         clear_i = 1'b0;
    logic         enable_i = 1'b0;
    logic         trigger_i = 1'b0;
    logic [W-1:0] n_out_i = '0;
    logic         k_start_o;
    logic         k_clear_o;
    logic         k_done_i = 1'b0;
    logic         k_ready_i = 1'b0;
    logic         k_idle_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] cnt_out_o;
    logic [W-1:0] cnt_start_o;
    logic         err_o;

    mmul_parallel_kernel_sequencer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .enable_i    (enable_i),
        .trigger_i   (trigger_i),
        .n_out_i     (n_out_i),
        .k_start_o   (k_start_o),
        .k_clear_o   (k_clear_o),
        .k_done_i    (k_done_i),
        .k_ready_i   (k_ready_i),
        .k_idle_i    (k_idle_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cnt_out_o   (cnt_out_o),
        .cnt_start_o (cnt_start_o),
        .err_o       (err_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cnt = 0;
    int fin_cnt = 0;
    int fin_cyc = 0;
    int last_done_cyc = 0;
    logic auto_done = 1'b0;
    int due_q[$];
    int s0, f0;

    always @(posedge clk_i) cyc = cyc + 1;

    // Mid-cycle monitor: counts start and done_o pulses.
    always @(negedge clk_i) begin
        if (k_start_o) begin
            start_cnt = start_cnt + 1;
            if (auto_done) due_q.push_back(cyc + 4);
        end
        if (done_o) begin
            fin_cnt = fin_cnt + 1;
            fin_cyc = cyc;
        end
        if (k_done_i) last_done_cyc = cyc;
    end

    // Kernel model: answers each start with a done four cycles later.
    always @(posedge clk_i) begin
        #1;
        if (auto_done) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                k_done_i = 1'b1;
                void'(due_q.pop_front());
            end else begin
                k_done_i = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input int n);
        n_out_i   = W'(n);
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
    endtask

    task automatic wait_fin(input int prev, input int max_cyc);
        int n;
        n = 0;
        while (fin_cnt == prev && n < max_cyc) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(fin_cnt > prev), 1);
    endtask

    initial begin
        // Reset
        #1 rst_ni = 1'b0;
        #3;
        chk("rst_start", 32'(k_start_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_cnt_out", 32'(cnt_out_o), 0);
        chk("rst_cnt_start", 32'(cnt_start_o), 0);
        chk("rst_err", 32'(err_o), 0);
        tick();
        tick();
        rst_ni = 1'b1;
        enable_i = 1'b1;
        k_ready_i = 1'b1;
        tick();

        // Three outputs, kernel answers each start after four cycles
        s0 = start_cnt; f0 = fin_cnt;
        auto_done = 1'b1;
        start_job(3);
        wait_fin(f0, 100);
        repeat (3) tick();
        chk("j3_starts", 32'(start_cnt - s0), 3);
        chk("j3_done_pulses", 32'(fin_cnt - f0), 1);
        chk("j3_done_latency", 32'(fin_cyc - last_done_cyc), 1);
        chk("j3_cnt_out", 32'(cnt_out_o), 3);
        chk("j3_cnt_start", 32'(cnt_start_o), 3);
        chk("j3_err", 32'(err_o), 0);
        chk("j3_busy", 32'(busy_o), 0);
        auto_done = 1'b0;
        k_done_i = 1'b0;

        // Empty job: straight to FINISH
        s0 = start_cnt;
        start_job(0);
        chk("j0_done", 32'(done_o), 1);
        chk("j0_busy", 32'(busy_o), 0);
        tick();
        chk("j0_done_clr", 32'(done_o), 0);
        chk("j0_starts", 32'(start_cnt - s0), 0);
        chk("j0_cnt_out", 32'(cnt_out_o), 0);
        chk("j0_cnt_start", 32'(cnt_start_o), 0);

        // Outstanding limit, then same-cycle slot release
        s0 = start_cnt; f0 = fin_cnt;
        start_job(4);
        repeat (5) tick();
        chk("j4_starts_cap", 32'(start_cnt - s0), 2);
        chk("j4_cnt_start_cap", 32'(cnt_start_o), 2);
        chk("j4_busy", 32'(busy_o), 1);
        chk("j4_no_start", 32'(k_start_o), 0);
        k_done_i = 1'b1;
        tick();
        k_done_i = 1'b0;
        chk("j4_start_after_done", 32'(k_start_o), 1);
        chk("j4_cnt_out1", 32'(cnt_out_o), 1);
        for (int i = 0; i < 3; i++) begin
            repeat (3) tick();
            k_done_i = 1'b1;
            tick();
            k_done_i = 1'b0;
        end
        wait_fin(f0, 20);
        chk("j4_starts", 32'(start_cnt - s0), 4);
        chk("j4_cnt_out", 32'(cnt_out_o), 4);
        chk("j4_err", 32'(err_o), 0);

        // enable_i dropped mid-job
        s0 = start_cnt; f0 = fin_cnt;
        start_job(5);
        repeat (5) tick();
        chk("j5_starts_pre", 32'(start_cnt - s0), 2);
        enable_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            k_done_i = 1'b1;
            tick();
            k_done_i = 1'b0;
            repeat (3) tick();
        end
        chk("j5_starts_stalled", 32'(start_cnt - s0), 2);
        chk("j5_cnt_out_stalled", 32'(cnt_out_o), 2);
        chk("j5_busy_stalled", 32'(busy_o), 1);
        auto_done = 1'b1;
        enable_i = 1'b1;
        wait_fin(f0, 100);
        chk("j5_starts", 32'(start_cnt - s0), 5);
        chk("j5_cnt_out", 32'(cnt_out_o), 5);
        chk("j5_err", 32'(err_o), 0);
        auto_done = 1'b0;
        k_done_i = 1'b0;
        tick();

        // Protocol errors and clear
        k_done_i = 1'b1;
        tick();
        k_done_i = 1'b0;
        chk("err_idle_done", 32'(err_o), 1);
        tick();
        chk("err_idle_hold", 32'(err_o), 1);
        clear_i = 1'b1;
        #1;
        chk("k_clear_a", 32'(k_clear_o), 1);
        tick();
        clear_i = 1'b0;
        chk("err_cleared_a", 32'(err_o), 0);
        k_ready_i = 1'b0;
        start_job(2);
        tick();
        k_done_i = 1'b1;
        tick();
        k_done_i = 1'b0;
        chk("err_legal_done", 32'(err_o), 0);
        chk("err_cnt_out1", 32'(cnt_out_o), 1);
        k_done_i = 1'b1;
        tick();
        k_done_i = 1'b0;
        chk("err_extra_done", 32'(err_o), 1);
        chk("err_extra_not_counted", 32'(cnt_out_o), 1);
        repeat (3) tick();
        chk("err_sticky", 32'(err_o), 1);
        chk("err_busy", 32'(busy_o), 1);
        clear_i = 1'b1;
        #1;
        chk("k_clear_b", 32'(k_clear_o), 1);
        chk("clear_no_start", 32'(k_start_o), 0);
        tick();
        clear_i = 1'b0;
        chk("clear_busy", 32'(busy_o), 0);
        chk("clear_err", 32'(err_o), 0);
        chk("clear_cnt_start", 32'(cnt_start_o), 0);
        start_job(2);
        tick();
        k_idle_i = 1'b1;
        tick();
        k_idle_i = 1'b0;
        chk("err_idle_pending", 32'(err_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;

        // Clear during WAIT, then a normal one-output job
        k_ready_i = 1'b1;
        start_job(4);
        repeat (5) tick();
        k_ready_i = 1'b0;
        k_done_i = 1'b1;
        tick();
        k_done_i = 1'b0;
        chk("cw_cnt_start", 32'(cnt_start_o), 2);
        chk("cw_cnt_out", 32'(cnt_out_o), 1);
        f0 = fin_cnt;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("cw_busy", 32'(busy_o), 0);
        chk("cw_cnt_start0", 32'(cnt_start_o), 0);
        chk("cw_cnt_out0", 32'(cnt_out_o), 0);
        repeat (3) tick();
        chk("cw_no_done", 32'(fin_cnt - f0), 0);
        k_ready_i = 1'b1;
        auto_done = 1'b1;
        s0 = start_cnt; f0 = fin_cnt;
        start_job(1);
        wait_fin(f0, 50);
        chk("j1_starts", 32'(start_cnt - s0), 1);
        chk("j1_cnt_out", 32'(cnt_out_o), 1);
        chk("j1_err", 32'(err_o), 0);
        auto_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
